memory_stage_ctrl: RTL

//  Memory-stage access controller for the pipelined datapath. Sits between the execute/memory latch and the

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/memory_stage_if.sv | 42 ++++
 rtl/stall_counter.sv | 19 +
 rtl/memory_stage_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, memory-stage FSM states
// and the snapshot of a data-cache access that is waiting on the cache.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } memstate_t;

    // Held from the missing cycle until dhit so the cache sees a stable request.
    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
    } memreq_t;

endpackage

// File: rtl/memory_stage_if.sv
// Signal bundle around the memory-stage controller: the block's view (ms)
// and the driving/observing side (tb).
interface memory_stage_if #(parameter int CNT_W = 16) (input logic CLK);
    import cpu_types_pkg::*;

    logic             RST;
    logic             in_valid;
    logic             in_dREN;
    logic             in_dWEN;
    word_t            in_addr;
    word_t            in_store;
    logic             in_halt;
    logic             flush;
    logic             dhit;
    word_t            dmemload;
    logic             dmemREN;
    logic             dmemWEN;
    word_t            dmemaddr;
    word_t            dmemstore;
    logic             mem_en;
    logic             mem_flush;
    word_t            mem_dload;
    logic             mem_dhit;
    logic             stall;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport ms (
        input  CLK, RST, in_valid, in_dREN, in_dWEN, in_addr, in_store, in_halt,
               flush, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_en, mem_flush,
               mem_dload, mem_dhit, stall, halted, stall_cnt
    );

    modport tb (
        input  CLK, dmemREN, dmemWEN, dmemaddr, dmemstore, mem_en, mem_flush,
               mem_dload, mem_dhit, stall, halted, stall_cnt,
        output RST, in_valid, in_dREN, in_dWEN, in_addr, in_store, in_halt,
               flush, dhit, dmemload
    );

endinterface

// File: rtl/stall_counter.sv
// Saturating event counter: counts cycles with inc high and parks at all-ones.
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/memory_stage_ctrl.sv
// Memory-stage access controller: issues data-cache requests, stalls the front
// of the pipe on a miss, and steers en/flush/dload/dhit into the memory latch.
module memory_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic             in_dREN,
    input  logic             in_dWEN,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_store,
    input  logic             in_halt,
    input  logic             flush,
    input  logic             dhit,
    input  logic [31:0]      dmemload,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic             mem_en,
    output logic             mem_flush,
    output logic [31:0]      mem_dload,
    output logic             mem_dhit,
    output logic             stall,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    memstate_t state;
    memreq_t   req_q;
    logic      squash_q;

    logic mem_op;
    logic rd_op;
    logic wr_op;
    logic halt_go;
    logic stall_inc;

    // A simultaneous read and write request is resolved as a read.
    assign mem_op  = in_valid & (in_dREN | in_dWEN);
    assign rd_op   = in_dREN;
    assign wr_op   = in_dWEN & ~in_dREN;
    assign halt_go = in_valid & in_halt & ~flush;

    // Hits complete in the issuing cycle, so the outputs are a function of the
    // current state and the live cache response; reset forces them all low.
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        mem_en    = 1'b0;
        mem_flush = 1'b0;
        mem_dload = '0;
        mem_dhit  = 1'b0;
        stall     = 1'b0;
        halted    = 1'b0;
        if (!RST) begin
            unique case (state)
                IDLE: begin
                    if (halt_go) begin
                        mem_en = 1'b1;
                    end else if (mem_op && !flush) begin
                        dmemREN   = rd_op;
                        dmemWEN   = wr_op;
                        dmemaddr  = in_addr;
                        dmemstore = in_store;
                        if (dhit) begin
                            mem_en    = 1'b1;
                            mem_dload = dmemload;
                            mem_dhit  = 1'b1;
                        end else begin
                            stall = 1'b1;
                        end
                    end else begin
                        mem_en    = 1'b1;
                        mem_flush = flush;
                    end
                end
                WAIT: begin
                    dmemREN   = req_q.ren;
                    dmemWEN   = req_q.wen;
                    dmemaddr  = req_q.addr;
                    dmemstore = req_q.store;
                    if (dhit) begin
                        mem_en    = 1'b1;
                        mem_dload = dmemload;
                        mem_dhit  = 1'b1;
                        mem_flush = squash_q | flush;
                    end else begin
                        stall = 1'b1;
                    end
                end
                HALTED: begin
                    stall  = 1'b1;
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A flush during a miss cannot withdraw the request, so it is remembered
    // and applied to the latch when the cache finally answers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            req_q    <= '0;
            squash_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (halt_go) begin
                        state <= HALTED;
                    end else if (mem_op && !flush && !dhit) begin
                        req_q.ren   <= rd_op;
                        req_q.wen   <= wr_op;
                        req_q.addr  <= in_addr;
                        req_q.store <= in_store;
                        squash_q    <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (dhit) begin
                        squash_q <= 1'b0;
                        state    <= IDLE;
                    end else if (flush) begin
                        squash_q <= 1'b1;
                    end
                end
                HALTED: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_inc = stall & (state != HALTED);

    stall_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule
